// File: rtl/ifetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues bus requests, and buffers
// fetched {pc, inst} pairs in a small FIFO that decode drains from the head.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] PC_START = 32'h0001_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] IDT,
    input  logic        ACKI_n,
    output logic [31:0] IAD,
    output logic        IREQ,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        deq,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_pc_4,
    output logic [31:0] out_inst
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [31:0]   mem_pc   [DEPTH];
    logic [31:0]   mem_inst [DEPTH];

    logic full;
    logic empty;
    logic enq;
    logic do_deq;

    // Handshakes: a bus beat completes on an edge with IREQ=1 and ACKI_n=0; the head
    // entry is consumed on an edge with out_valid=1 and deq=1. Redirect and reset
    // override both, so neither a wrong-path beat nor a stale head can slip through.
    assign full   = (count == FULL_CNT);
    assign empty  = (count == '0);
    assign IREQ   = !rst && !full;
    assign IAD    = fetch_pc;
    assign enq    = IREQ && !ACKI_n && !redirect;
    assign do_deq = deq && !empty && !redirect && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= PC_START;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (enq) begin
                fetch_pc <= fetch_pc + 32'd4;
                wr_ptr   <= wr_ptr + 1'b1;
            end
            if (do_deq) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (enq && !do_deq) begin
                count <= count + 1'b1;
            end else if (!enq && do_deq) begin
                count <= count - 1'b1;
            end
        end
    end

    // Storage carries no reset; entries are only observable once count covers them.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem_pc[wr_ptr]   <= fetch_pc;
            mem_inst[wr_ptr] <= IDT;
        end
    end

    always_comb begin
        out_valid = !rst && !empty;
        out_pc    = 32'h0;
        out_pc_4  = 32'h0;
        out_inst  = NOP_INST;
        if (out_valid) begin
            out_pc   = mem_pc[rd_ptr];
            out_pc_4 = mem_pc[rd_ptr] + 32'd4;
            out_inst = mem_inst[rd_ptr];
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Self-checking bench for ifetch_queue: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_ifetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] PC_START = 32'h0001_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] IDT;
    logic        ACKI_n;
    logic [31:0] IAD;
    logic        IREQ;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        deq;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_pc_4;
    logic [31:0] out_inst;

    ifetch_queue #(.DEPTH(DEPTH), .PC_START(PC_START), .NOP_INST(NOP_INST)) dut (
        .clk        (clk),
        .rst        (rst),
        .IDT        (IDT),
        .ACKI_n     (ACKI_n),
        .IAD        (IAD),
        .IREQ       (IREQ),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .deq        (deq),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_pc_4   (out_pc_4),
        .out_inst   (out_inst)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard: expected FIFO contents {pc, inst} and expected fetch PC
    logic [63:0] exp_q[$];
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // driver: apply one cycle of inputs, check outputs mid-cycle, then advance the model
    task automatic step(input logic r, input logic an, input logic [31:0] d,
                        input logic rd, input logic [31:0] rp, input logic dq);
        logic        v;
        logic        ireq;
        logic [63:0] head;
        @(negedge clk);
        rst = r; ACKI_n = an; IDT = d; redirect = rd; redirect_pc = rp; deq = dq;
        #1;
        v    = !r && (exp_q.size() != 0);
        ireq = !r && (exp_q.size() != DEPTH);
        head = v ? exp_q[0] : 64'h0;
        check("iad",       IAD, m_pc);
        check("ireq",      {31'h0, IREQ}, {31'h0, ireq});
        check("out_valid", {31'h0, out_valid}, {31'h0, v});
        check("out_pc",    out_pc,   v ? head[63:32] : 32'h0);
        check("out_pc_4",  out_pc_4, v ? head[63:32] + 32'd4 : 32'h0);
        check("out_inst",  out_inst, v ? head[31:0] : NOP_INST);
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_pc = PC_START;
        end else if (rd) begin
            exp_q.delete();
            m_pc = rp & 32'hFFFF_FFFC;
        end else begin
            if (dq && exp_q.size() != 0) void'(exp_q.pop_front());
            if (ireq && !an) begin
                exp_q.push_back({m_pc, d});
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic ack(input logic [31:0] d, input logic dq);
        step(1'b0, 1'b0, d, 1'b0, 32'h0, dq);
    endtask

    task automatic idle(input logic dq);
        step(1'b0, 1'b1, $urandom, 1'b0, 32'h0, dq);
    endtask

    initial begin
        rst = 1'b1; ACKI_n = 1'b1; IDT = '0; redirect = 1'b0; redirect_pc = '0; deq = 1'b0;
        exp_q.delete();
        m_pc = PC_START;

        // streaming at zero wait states
        do_reset();
        idle(1'b1);
        #1 check("rst_iad", IAD, 32'h0001_0000);
        ack(32'hA000_0000, 1'b1);
        #1 check("s_pc",   out_pc,   32'h0001_0000);
        check("s_pc4",     out_pc_4, 32'h0001_0004);
        check("s_inst",    out_inst, 32'hA000_0000);
        check("s_iad",     IAD,      32'h0001_0004);
        for (int i = 1; i < 6; i++) ack(32'hA000_0000 + i, 1'b1);

        // wait states drain the queue to a NOP bubble
        do_reset();
        ack(32'hB000_0000, 1'b1);
        for (int i = 0; i < 3; i++) idle(1'b1);
        #1 check("w_valid", {31'h0, out_valid}, 32'h0);
        check("w_nop",  out_inst, NOP_INST);
        check("w_iad",  IAD, 32'h0001_0004);
        check("w_ireq", {31'h0, IREQ}, 32'h1);
        ack(32'hB000_0001, 1'b1);
        #1 check("w_pc", out_pc, 32'h0001_0004);

        // fill to DEPTH, then a single dequeue re-opens the bus
        do_reset();
        for (int i = 0; i < DEPTH; i++) ack(32'hC000_0000 + i, 1'b0);
        #1 check("f_ireq", {31'h0, IREQ}, 32'h0);
        check("f_iad", IAD, 32'h0001_0010);
        ack(32'hC0DE_0000, 1'b1);
        #1 check("f_ireq2", {31'h0, IREQ}, 32'h1);
        check("f_pc", out_pc, 32'h0001_0004);
        ack(32'hC000_0004, 1'b0);

        // redirect with an ack in the same cycle drops the wrong-path beat
        do_reset();
        for (int i = 0; i < 3; i++) ack(32'hD000_0000 + i, 1'b0);
        step(1'b0, 1'b0, 32'hBAD0_BAD0, 1'b1, 32'h0002_0003, 1'b0);
        #1 check("r_valid", {31'h0, out_valid}, 32'h0);
        check("r_iad", IAD, 32'h0002_0000);
        ack(32'hD000_1000, 1'b0);
        #1 check("r_pc", out_pc, 32'h0002_0000);
        check("r_inst", out_inst, 32'hD000_1000);

        // 32-bit PC wraparound
        step(1'b0, 1'b1, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        ack(32'hE000_0000, 1'b0);
        #1 check("x_pc", out_pc, 32'hFFFF_FFFC);
        check("x_pc4", out_pc_4, 32'h0000_0000);
        check("x_iad", IAD, 32'h0000_0000);

        // pointer wrap keeps FIFO order
        for (int i = 0; i < 10; i++) ack(32'hF000_0000 + i, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 6; i++) idle(1'b1);

        // reset in the middle of a wait state, with an ack during reset
        do_reset();
        ack(32'h1111_0000, 1'b0);
        ack(32'h1111_0001, 1'b0);
        idle(1'b0);
        step(1'b1, 1'b0, 32'h2222_2222, 1'b0, 32'h0, 1'b0);
        idle(1'b0);
        #1 check("m_valid", {31'h0, out_valid}, 32'h0);
        check("m_iad", IAD, 32'h0001_0000);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 99) < 2),
                 1'($urandom_range(0, 99) < 40),
                 $urandom,
                 1'($urandom_range(0, 99) < 5),
                 $urandom,
                 1'($urandom_range(0, 99) < 55));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ifetch_queue.md
Name: ifetch_queue

Overview:
Instruction fetch front end between the external instruction bus (IAD/IDT/ACKI_n) and the IF/ID pipeline register. It owns the fetch PC and issues fetch requests. It tolerates any number of bus wait states and buffers fetched instructions with their PC and PC+4 in a small FIFO. The FIFO is drained by decode. When the EX stage signals a taken branch or jump, the block flushes the FIFO and redirects the fetch PC. When empty, it presents a NOP bubble so the pipeline never sees stale data.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
PC_START, 32'h10000, fetch PC after reset
NOP_INST, 32'h00000013, instruction presented when no valid entry (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
IDT  in  32  instruction data from bus, valid when ACKI_n low
ACKI_n  in  1  active-low bus acknowledge for current IAD
IAD  out  32  fetch address
IREQ  out  1  fetch request; IAD valid while high
redirect  in  1  taken branch/jump from EX (pcsrc)
redirect_pc  in  32  new fetch target (PC_IN)
deq  in  1  decode consumes head entry this cycle (not stalled)
out_valid  out  1  head entry valid
out_pc  out  32  PC of head instruction
out_pc_4  out  32  out_pc + 4
out_inst  out  32  head instruction

Behaviour:
- State:
  - fetch_pc[31:0]
  - FIFO of DEPTH entries {pc, inst}
  - wr_ptr and rd_ptr, each clog2(DEPTH) bits, wrapping modulo DEPTH
  - count, clog2(DEPTH)+1 bits
- Reset (rst high at edge):
  - fetch_pc=PC_START, count=0, both pointers 0.
  - While rst is high: IREQ=0, out_valid=0.
  - Any ack arriving in a reset cycle is discarded. Reset mid-wait-state abandons the transaction.
- IAD = fetch_pc at all times.
- IREQ = !rst && (count != DEPTH). There is no full-bypass: if full, IREQ stays low even when deq is high.
- Bus beat completes at the edge where IREQ=1 and ACKI_n=0. Zero-wait operation means one beat per cycle. While ACKI_n=1, IAD and IREQ hold and no state changes.
- Enqueue (enq = IREQ & !ACKI_n & !redirect & !rst):
  - write {fetch_pc, IDT} at wr_ptr, then wr_ptr++.
  - fetch_pc <= fetch_pc + 4, mod 2^32.
- Dequeue (do_deq = deq & (count != 0) & !redirect & !rst): rd_ptr++.
- count update: +1 on enq only, -1 on do_deq only, unchanged if both or neither.
- Empty queue:
  - enq and deq in the same cycle: there is no bypass. The entry is written, deq is ignored, and out_valid rises next cycle.
  - deq while empty is ignored.
- Redirect (priority over enq/deq, below rst):
  - count=0, wr_ptr=rd_ptr=0.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - An ack arriving in the redirect cycle is dropped, so the wrong-path instruction is never enqueued.
  - First new-path request is issued the cycle after redirect.
- Outputs are combinational from the head entry:
  - out_valid = (count != 0).
  - If valid: out_pc = entry.pc, out_pc_4 = entry.pc + 4 (mod 2^32), out_inst = entry.inst.
  - If not valid: out_pc=0, out_pc_4=0, out_inst=NOP_INST.
- Latency: IDT accepted at edge N appears on out_* in cycle N+1 (earliest).

Test Plan:
- Reset, then ACKI_n=0 every cycle and deq=1:
  - cycle 0: IAD=0x10000.
  - cycle 1: out_valid=1, out_pc=0x10000, out_pc_4=0x10004, out_inst=IDT of beat 0, IAD=0x10004.
  - Thereafter one instruction per cycle, count stays at 1.
- Wait states: hold ACKI_n=1 for 3 cycles after the first beat.
  - IAD stays 0x10004 and IREQ stays 1.
  - Queue drains to out_valid=0 with out_inst=0x00000013.
  - The 4th-cycle ack enqueues pc 0x10004.
- Fill: deq=0 with acks every cycle.
  - After 4 beats: count=4, IREQ=0, IAD=0x10010 held.
  - One deq cycle: next cycle IREQ=1, count=3, out_pc=0x10004.
- Redirect with 3 entries queued and ack in the same cycle, redirect_pc=0x20003.
  - Next cycle: out_valid=0, IAD=0x20000.
  - The dropped beat never appears.
  - The next ack yields out_pc=0x20000.
- Wrap: redirect_pc=0xFFFFFFFC, then ack.
  - out_pc=0xFFFFFFFC, out_pc_4=0x00000000, next IAD=0x00000000.
  - Also: DEPTH pointer wrap over 10 enq/deq cycles keeps FIFO order.
- Reset asserted mid-wait-state with 2 entries queued and ACKI_n=0 during rst.
  - Next cycle: count=0, IAD=0x10000, no entry written.
